// File: rtl/apb_bridge_pkg.sv
// Shared types and sizing helpers for the APB slave bridge.
package apb_bridge_pkg;

  localparam int MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  err;
  } resp_t;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // Wide enough to hold TIMEOUT_CYCLES itself; a disabled timeout still gets one bit.
  function automatic int tmo_cnt_width(input int timeout_cycles);
    return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_slave_bridge_if.sv
// APB slave port plus the downstream valid/ready request bus, as seen by the bridge.
interface apb_slave_bridge_if
  import apb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  localparam int STRB_W = strb_width(DATA_WIDTH);

  logic                  i_psel;
  logic                  i_penable;
  logic                  i_pwrite;
  logic [ADDR_WIDTH-1:0] i_paddr;
  logic [DATA_WIDTH-1:0] i_pwdata;
  logic [STRB_W-1:0]     i_pstrb;
  logic [DATA_WIDTH-1:0] o_prdata;
  logic                  o_pready;
  logic                  o_pslverr;

  logic                  o_valid;
  logic                  o_rd0_wr1;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic [STRB_W-1:0]     o_wr_strb;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_rd_data;
  logic                  i_rd_valid;
  logic                  i_rd_err;

  modport slave (
    input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_pstrb,
    output o_prdata, o_pready, o_pslverr,
    output o_valid, o_rd0_wr1, o_addr, o_wr_data, o_wr_strb,
    input  i_ready, i_rd_data, i_rd_valid, i_rd_err
  );

  modport master (
    output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_pstrb,
    input  o_prdata, o_pready, o_pslverr,
    input  o_valid, o_rd0_wr1, o_addr, o_wr_data, o_wr_strb,
    output i_ready, i_rd_data, i_rd_valid, i_rd_err
  );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational window hit, word-alignment check and window-relative offset.
module apb_addr_decode #(
  parameter longint unsigned BASE_ADDR    = 0,
  parameter longint unsigned WINDOW_BYTES = 4096,
  parameter int              DATA_WIDTH   = 32,
  parameter int              ADDR_WIDTH   = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_hit,
  output logic                  o_misaligned,
  output logic [ADDR_WIDTH-1:0] o_offset
);

  localparam int                    LSB_W  = $clog2(DATA_WIDTH / 8);
  localparam int                    AW1    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [AW1-1:0]        WINDOW = AW1'(WINDOW_BYTES);

  // Addresses below BASE wrap to a large offset, so one compare covers both bounds.
  assign o_offset = i_addr - BASE;
  assign o_hit    = ({1'b0, o_offset} < WINDOW);

  if (LSB_W == 0) begin : g_byte_bus
    assign o_misaligned = 1'b0;
  end else begin : g_word_bus
    assign o_misaligned = |i_addr[LSB_W-1:0];
  end

endmodule

// File: rtl/apb_slave_bridge.sv
// APB3/APB4 slave that forwards one transfer at a time onto the valid/ready request bus.
module apb_slave_bridge
  import apb_bridge_pkg::*;
#(
  parameter int              DATA_WIDTH     = 32,
  parameter int              ADDR_WIDTH     = 32,
  parameter longint unsigned BASE_ADDR      = 0,
  parameter longint unsigned WINDOW_BYTES   = 4096,
  parameter int              TIMEOUT_CYCLES = 256
) (
  input  logic               i_clk_apb,
  input  logic               i_rst_apb,
  apb_slave_bridge_if.slave  bus
);

  localparam int               STRB_W   = strb_width(DATA_WIDTH);
  localparam int               CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam resp_t            RESP_OK  = '0;
  localparam resp_t            RESP_ERR = '{data: '0, err: 1'b1};

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  resp_t                 resp_q, resp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  dec_hit;
  logic                  dec_misaligned;
  logic [ADDR_WIDTH-1:0] dec_offset;
  logic                  tmo_hit;

  function automatic resp_t rd_resp(input logic [DATA_WIDTH-1:0] data, input logic err);
    resp_t r;
    r.err  = err;
    r.data = err ? '0 : MAX_DATA_W'(data);
    return r;
  endfunction

  apb_addr_decode #(
    .BASE_ADDR    (BASE_ADDR),
    .WINDOW_BYTES (WINDOW_BYTES),
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_decode (
    .i_addr       (bus.i_paddr),
    .o_hit        (dec_hit),
    .o_misaligned (dec_misaligned),
    .o_offset     (dec_offset)
  );

  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_psel && !bus.i_penable) begin
          wr_d    = bus.i_pwrite;
          addr_d  = dec_offset;
          wdata_d = bus.i_pwrite ? bus.i_pwdata : '0;
          strb_d  = bus.i_pwrite ? bus.i_pstrb : '0;
          if (!dec_hit || dec_misaligned) begin
            resp_d  = RESP_ERR;
            state_d = ST_RESP;
          end else begin
            resp_d  = RESP_OK;
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (TMO_EN) cnt_d = cnt_q + 1'b1;
        // A read accepted on the last allowed cycle without data still times out.
        if (bus.i_ready && wr_q) begin
          resp_d  = RESP_OK;
          state_d = ST_RESP;
        end else if (bus.i_ready && bus.i_rd_valid) begin
          resp_d  = rd_resp(bus.i_rd_data, bus.i_rd_err);
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          resp_d  = RESP_ERR;
          state_d = ST_RESP;
        end else if (bus.i_ready) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (TMO_EN) cnt_d = cnt_q + 1'b1;
        if (bus.i_rd_valid) begin
          resp_d  = rd_resp(bus.i_rd_data, bus.i_rd_err);
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          resp_d  = RESP_ERR;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
    if (i_rst_apb) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      resp_q  <= RESP_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_valid   = (state_q == ST_REQ);
  assign bus.o_rd0_wr1 = wr_q;
  assign bus.o_addr    = addr_q;
  assign bus.o_wr_data = wdata_q;
  assign bus.o_wr_strb = strb_q;
  assign bus.o_pready  = (state_q == ST_RESP);
  assign bus.o_prdata  = bus.o_pready ? resp_q.data[DATA_WIDTH-1:0] : '0;
  assign bus.o_pslverr = bus.o_pready & resp_q.err;

  if (DATA_WIDTH < MAX_DATA_W) begin : g_narrow
    logic unused_resp_hi;
    assign unused_resp_hi = |resp_q.data[MAX_DATA_W-1:DATA_WIDTH];
  end

endmodule

// File: tb/tb_apb_slave_bridge.sv
// Bench for apb_slave_bridge: vector table through an APB master task, scoreboarded responses,
// plus hand-written reset and late-read-data sequences.
module tb_apb_slave_bridge;
  import apb_bridge_pkg::*;

  localparam int              DW   = 32;
  localparam int              AW   = 32;
  localparam int              SW   = DW / 8;
  localparam longint unsigned BASE = 0;
  localparam longint unsigned WIN  = 4096;
  localparam int              TMO  = 8;
  localparam int              NVEC = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_slave_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_slave_bridge #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (BASE),
    .WINDOW_BYTES   (WIN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk_apb (clk),
    .i_rst_apb (rst),
    .bus       (bus)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            ready_dly;  // valid cycles before i_ready; large = never
    int            rdv_dly;    // cycles after handshake to i_rd_valid; -1 = never
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          late_rdv;   // also pulse i_rd_valid during the RESP cycle
    logic          exp_err;
    logic [DW-1:0] exp_data;
    int            exp_valid;
    int            exp_lat;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [SW-1:0] strb, input int rdy, input int rdv,
                              input logic [DW-1:0] rdd, input logic rde, input logic late,
                              input logic xerr, input logic [DW-1:0] xdata, input int xv, input int xlat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.ready_dly = rdy; v.rdv_dly = rdv; v.rd_data = rdd; v.rd_err = rde; v.late_rdv = late;
    v.exp_err = xerr; v.exp_data = xdata; v.exp_valid = xv; v.exp_lat = xlat;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({bus.o_valid, bus.o_rd0_wr1, bus.o_addr, bus.o_wr_data, bus.o_wr_strb,
                 bus.o_prdata, bus.o_pready, bus.o_pslverr});
  endfunction

  task automatic idle_inputs();
    bus.i_psel = 1'b0; bus.i_penable = 1'b0; bus.i_pwrite = 1'b0;
    bus.i_paddr = '0; bus.i_pwdata = '0; bus.i_pstrb = '0;
    bus.i_ready = 1'b0; bus.i_rd_valid = 1'b0; bus.i_rd_err = 1'b0; bus.i_rd_data = '0;
  endtask

  // Called at a negedge; drives the setup phase there and returns at the negedge after RESP.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t          e;
    int            n, vcnt, hs_n;
    bit            done;
    logic [AW-1:0] exp_off;
    e.data = v.exp_data; e.err = v.exp_err; e.lat = v.exp_lat;
    sb_q.push_back(e);
    exp_off = v.addr - AW'(BASE);
    bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = v.wr;
    bus.i_paddr = v.addr; bus.i_pwdata = v.wdata; bus.i_pstrb = v.strb;
    bus.i_ready = 1'b0; bus.i_rd_valid = 1'b0; bus.i_rd_err = 1'b0; bus.i_rd_data = '0;
    n = 0; vcnt = 0; hs_n = -1; done = 1'b0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      bus.i_penable = 1'b1; bus.i_ready = 1'b0; bus.i_rd_valid = 1'b0; bus.i_rd_err = 1'b0;
      if (bus.o_pready) begin
        done = 1'b1;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s pready: got unexpected response, required none", tag);
        end else begin
          e = sb_q.pop_front();
          check({tag, " prdata"}, 128'(bus.o_prdata), 128'(e.data));
          check({tag, " pslverr"}, 128'(bus.o_pslverr), 128'(e.err));
          check({tag, " latency"}, 128'(n), 128'(e.lat));
        end
        if (v.late_rdv) begin
          bus.i_rd_valid = 1'b1; bus.i_rd_err = 1'b1; bus.i_rd_data = 32'h5555_AAAA;
        end
      end else begin
        if (bus.o_valid) begin
          vcnt++;
          check({tag, " payload"}, 128'({bus.o_rd0_wr1, bus.o_addr, bus.o_wr_strb}),
                128'({v.wr, exp_off, (v.wr ? v.strb : SW'(0))}));
          if (v.wr) check({tag, " wr_data"}, 128'(bus.o_wr_data), 128'(v.wdata));
          if (vcnt - 1 == v.ready_dly) begin
            bus.i_ready = 1'b1;
            hs_n = n;
          end
        end
        if (!v.wr && hs_n >= 0 && v.rdv_dly >= 0 && n - hs_n == v.rdv_dly) begin
          bus.i_rd_valid = 1'b1; bus.i_rd_err = v.rd_err; bus.i_rd_data = v.rd_data;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s pready: got none in 64 cycles, required %0d", tag, v.exp_lat);
    end
    check({tag, " valid cycles"}, 128'(vcnt), 128'(v.exp_valid));
    @(negedge clk);
    bus.i_psel = 1'b0; bus.i_penable = 1'b0;
    bus.i_ready = 1'b0; bus.i_rd_valid = 1'b0; bus.i_rd_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0,   -1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1, 2);
    vecs[1]  = mk(1'b0, 32'h20,   32'h0,        4'h0, 3,    2, 32'hA5A50001, 1'b0, 1'b0, 1'b0, 32'hA5A50001, 4, 7);
    vecs[2]  = mk(1'b0, 32'h1000, 32'h0,        4'h0, 0,    0, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h0,        0, 1);
    vecs[3]  = mk(1'b0, 32'h2,    32'h0,        4'h0, 0,    0, 32'h22222222, 1'b0, 1'b0, 1'b1, 32'h0,        0, 1);
    vecs[4]  = mk(1'b0, 32'h30,   32'h0,        4'h0, 0,    0, 32'h12345678, 1'b1, 1'b0, 1'b1, 32'h0,        1, 2);
    vecs[5]  = mk(1'b1, 32'h44,   32'h0BADF00D, 4'h5, 1,   -1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        2, 3);
    vecs[6]  = mk(1'b0, 32'hFFC,  32'h0,        4'h0, 0,    0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 1, 2);
    vecs[7]  = mk(1'b0, 32'h24,   32'h0,        4'h0, 1,    3, 32'h0000BEEF, 1'b0, 1'b0, 1'b0, 32'h0000BEEF, 2, 6);
    vecs[8]  = mk(1'b0, 32'h40,   32'h0,        4'h0, 255, -1, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        8, 9);
    vecs[9]  = mk(1'b0, 32'h48,   32'h0,        4'h0, 0,   -1, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1, 9);
    vecs[10] = mk(1'b1, 32'h11,   32'h00000001, 4'hF, 0,   -1, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        0, 1);
    vecs[11] = mk(1'b1, 32'h0,    32'hFFFFFFFF, 4'h8, 0,   -1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1, 2);

    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset outputs", all_outs(), 128'(0));
    check("reset state", 128'(dut.state_q), 128'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stray read data while idle must not produce a response.
    bus.i_rd_valid = 1'b1; bus.i_rd_err = 1'b1; bus.i_rd_data = 32'hBAD0BAD0;
    @(negedge clk);
    bus.i_rd_valid = 1'b0; bus.i_rd_err = 1'b0;
    check("late rdv idle", 128'({bus.o_pready, bus.o_valid, bus.o_pslverr}), 128'(0));
    check("late rdv state", 128'(dut.state_q), 128'(ST_IDLE));
    run_vec(mk(1'b0, 32'h50, 32'h0, 4'h0, 0, 0, 32'h600DDA7A, 1'b0, 1'b0, 1'b0, 32'h600DDA7A, 1, 2), "after late");

    // Reset while waiting for read data.
    bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = 1'b0; bus.i_paddr = 32'h60;
    @(negedge clk);
    bus.i_penable = 1'b1; bus.i_ready = 1'b1;
    check("rdwait req valid", 128'(bus.o_valid), 128'(1));
    @(negedge clk);
    bus.i_ready = 1'b0;
    check("rdwait entered", 128'(dut.state_q), 128'(ST_RD_WAIT));
    #2 rst = 1'b1;
    #1;
    check("rdwait reset outputs", all_outs(), 128'(0));
    check("rdwait reset state", 128'(dut.state_q), 128'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0; bus.i_psel = 1'b0; bus.i_penable = 1'b0;
    @(negedge clk);
    run_vec(mk(1'b1, 32'h70, 32'h13579BDF, 4'hF, 0, -1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 2), "after rst rdwait");

    // Reset while the request is being offered: o_valid must drop at once.
    bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = 1'b1; bus.i_paddr = 32'h80;
    bus.i_pwdata = 32'h0F0F0F0F; bus.i_pstrb = 4'h3;
    @(negedge clk);
    bus.i_penable = 1'b1;
    check("req valid", 128'(bus.o_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("req reset valid", 128'(bus.o_valid), 128'(0));
    check("req reset outputs", all_outs(), 128'(0));
    @(negedge clk);
    rst = 1'b0; bus.i_psel = 1'b0; bus.i_penable = 1'b0;
    @(negedge clk);
    run_vec(mk(1'b0, 32'h84, 32'h0, 4'h0, 2, 1, 32'h7E57DA7A, 1'b0, 1'b0, 1'b0, 32'h7E57DA7A, 3, 5), "after rst req");

    check("scoreboard empty", 128'(sb_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_bridge.md
Name: apb_slave_bridge

Overview:
Parametrised APB slave that converts APB3/APB4 transfers into single-outstanding requests on the team's valid/ready request bus (o_valid/i_ready, i_rd_valid return). It extends the existing APB slave with byte strobes, address-window decode, alignment checking, downstream read-error propagation and a programmable response timeout. It sits between the APB interconnect and one register/memory target.

Parameters:
DATA_WIDTH, 32, APB and request-bus data width; must be 8, 16, 32 or 64.
ADDR_WIDTH, 32, APB and request-bus address width.
BASE_ADDR, 0, first byte address decoded by this slave.
WINDOW_BYTES, 4096, decoded window size in bytes; must be a power of two and a multiple of DATA_WIDTH/8.
TIMEOUT_CYCLES, 256, cycles allowed from entering REQ until completion; 0 disables the timeout.

Ports:
i_clk_apb  in  1  clock
i_rst_apb  in  1  asynchronous active-high reset
i_psel  in  1  APB select
i_penable  in  1  APB enable
i_pwrite  in  1  1=write, 0=read
i_paddr  in  ADDR_WIDTH  APB byte address
i_pwdata  in  DATA_WIDTH  APB write data
i_pstrb  in  DATA_WIDTH/8  APB write strobes; tie all-ones for APB3
o_prdata  out  DATA_WIDTH  APB read data
o_pready  out  1  APB ready
o_pslverr  out  1  APB error
o_valid  out  1  downstream request valid
o_rd0_wr1  out  1  downstream direction
o_addr  out  ADDR_WIDTH  downstream address, offset from BASE_ADDR
o_wr_data  out  DATA_WIDTH  downstream write data
o_wr_strb  out  DATA_WIDTH/8  downstream write strobes; 0 on reads
i_ready  in  1  downstream accepts the request
i_rd_data  in  DATA_WIDTH  downstream read data
i_rd_valid  in  1  downstream read data valid
i_rd_err  in  1  downstream read error, qualified by i_rd_valid

Behaviour:
- Reset (asynchronous, immediate) sets:
  - all outputs to 0
  - FSM to IDLE
  - timeout counter to 0
- Any outstanding request is abandoned on reset, and o_valid drops in the same cycle.
- FSM states: IDLE, REQ, RD_WAIT, RESP.
- IDLE:
  - On i_psel=1 and i_penable=0 (setup phase), register the address, data, direction and strobes.
  - Run the decode check. Decode fails if the address is outside [BASE_ADDR, BASE_ADDR+WINDOW_BYTES) or its low log2(DATA_WIDTH/8) bits are nonzero.
  - Decode fail: go to RESP with error=1 and data=0. No downstream request is issued.
  - Decode pass: go to REQ.
- REQ:
  - o_valid=1, with the payload held stable until the handshake (o_valid & i_ready sampled at a rising edge).
  - Write handshake: go to RESP, error=0.
  - Read handshake: if i_rd_valid is also 1 in that cycle, capture the data and go to RESP. Otherwise go to RD_WAIT.
- RD_WAIT:
  - On i_rd_valid: capture i_rd_data, set error=i_rd_err, go to RESP.
- RESP:
  - o_pready=1 for exactly one cycle, with o_prdata and o_pslverr driven from the captured values.
  - o_prdata is 0 for writes and for errors.
  - Next state is IDLE.
- o_pready is 0 in all states other than RESP.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or RD_WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 without completing, go to RESP with error=1 and data=0.
  - o_valid deasserts on the timeout edge.
  - A late i_rd_valid arriving while in IDLE or RESP is ignored.
- Latency: the minimum is one APB wait state. Setup at T0, handshake at T1, o_pready at T2.
- i_psel and i_penable are only sampled in IDLE. APB protocol violations during REQ, RD_WAIT or RESP do not alter the sequence.
- A back-to-back setup phase in the cycle after RESP is accepted normally.

Decomposition:
- Package apb_bridge_pkg:
  - state enum typedef
  - resp_t struct {data, err}
  - function computing the strobe width
  - localparam for the timeout counter width = $clog2(TIMEOUT_CYCLES+1)
- Sub-module apb_addr_decode: combinational window check and alignment check, producing hit/misaligned/offset. Parameters: BASE_ADDR, WINDOW_BYTES, DATA_WIDTH.

Test Plan:
- Write to 0x10 with pwdata=0xDEADBEEF, pstrb=0xF and i_ready tied 1. Required: o_valid for 1 cycle with o_addr=0x10, o_wr_strb=0xF; o_pready at setup+2; o_pslverr=0.
- Read from 0x20 with i_ready delayed 3 cycles and i_rd_valid 2 cycles after the handshake, rd_data=0xA5A5_0001. Required: o_prdata=0xA5A5_0001 with one pready pulse; the payload stays stable while waiting.
- Read from BASE_ADDR+WINDOW_BYTES, then a read from 0x2 (misaligned). Required for each: no o_valid, o_pready at setup+1 with o_pslverr=1 and o_prdata=0.
- Read with i_rd_valid=1 and i_rd_err=1. Required: o_pslverr=1 and o_prdata=0.
- TIMEOUT_CYCLES=8 with i_ready held 0. Required: o_valid for exactly 8 cycles, then o_pready with o_pslverr=1; a later i_rd_valid is ignored and the next transfer completes cleanly.
- Assert i_rst_apb while in RD_WAIT. Required: all outputs 0 immediately, state IDLE; a subsequent write completes normally.
